inst_sram_resp: RTL and testbench

INST_SRAM_RESP -- requirements
Module: inst_sram_resp

---
 rtl/inst_sram_resp_pkg.sv | 21 ++
 rtl/inst_sram_resp_if.sv | 28 ++
 rtl/inst_sram_beat_timer.sv | 32 +++
 rtl/inst_sram_resp.sv | 129 ++++++++++++
 tb/tb_inst_sram_resp.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/inst_sram_resp_pkg.sv
// Shared defines for the instruction-SRAM responder: FSM encodings, the nop
// word that stands in for a timed-out beat, and the line-buffer layout.
package inst_sram_resp_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } line_t;

    // Word address of one beat of an 8-byte line.
    function automatic logic [31:0] beat_addr(input logic [28:0] base, input logic hi);
        return {base, hi, 2'b00};
    endfunction

endpackage

// File: rtl/inst_sram_resp_if.sv
// Fetch-side and backing-memory-side signals of the instruction-SRAM responder.
interface inst_sram_resp_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [63:0] inst_sram_rdata;
    logic        stall_req;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    // Responder side.
    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  mem_ack, mem_rdata,
        output inst_sram_rdata, stall_req, mem_req, mem_addr, err
    );

    // Environment side: the fetch requester plus the backing memory.
    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output mem_ack, mem_rdata,
        input  inst_sram_rdata, stall_req, mem_req, mem_addr, err
    );
endinterface

// File: rtl/inst_sram_beat_timer.sv
// Per-beat wait counter: cleared at each beat start, flags expiry when
// MEM_TIMEOUT cycles of a beat have elapsed with no ack.
module inst_sram_beat_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_start,
    input  logic i_active,
    input  logic i_ack,
    output logic o_expire
);

    localparam logic [7:0] LAST_CNT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Expire in the last allowed cycle of a beat unless the ack arrives in it.
    assign o_expire = i_active && !i_ack && (r_cnt == LAST_CNT);

    // Count cycles spent waiting in the current beat; saturate at the limit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= 8'd0;
        end else if (i_start) begin
            r_cnt <= 8'd0;
        end else if (i_active && (r_cnt != LAST_CNT)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction-SRAM responder: serves 64-bit fetch lines from a one-line buffer
// filled by two word beats from the backing memory.
// Optional feature: define INST_SRAM_LINE_HIT_EN to keep the line for reuse;
// otherwise the line is dropped after each served fetch.
module inst_sram_resp
    import inst_sram_resp_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             resetn,
    inst_sram_resp_if.slave  io_bus
);

    logic [1:0]  r_state, w_state_nxt;
    logic [28:0] r_base, w_base_nxt;
    logic [28:0] r_tag, w_tag_nxt;
    logic        r_line_valid, w_line_valid_nxt;
    line_t       r_line, w_line_nxt;
    logic        r_err, w_err_nxt;

    logic        w_hit, w_miss, w_in_beat, w_expire, w_advance, w_timer_start;
    logic [31:0] w_word;
    logic        w_unused;

    // Write enables/data and the in-line byte offset never affect the fetch.
    assign w_unused = ^{io_bus.inst_sram_wen, io_bus.inst_sram_wdata, io_bus.inst_sram_addr[2:0]};

    assign w_hit     = (r_state == S_IDLE) && r_line_valid
                       && (r_tag == io_bus.inst_sram_addr[31:3]);
    assign w_miss    = (r_state == S_IDLE) && io_bus.inst_sram_en && !w_hit;
    assign w_in_beat = (r_state == S_BEAT0) || (r_state == S_BEAT1);
    assign w_advance = w_in_beat && (io_bus.mem_ack || w_expire);
    assign w_word    = io_bus.mem_ack ? io_bus.mem_rdata : NOP_WORD;

    assign w_timer_start = (r_state == S_IDLE) || ((r_state == S_BEAT0) && w_advance);

    inst_sram_beat_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_beat_timer (
        .clk      (clk),
        .resetn   (resetn),
        .i_start  (w_timer_start),
        .i_active (w_in_beat),
        .i_ack    (io_bus.mem_ack),
        .o_expire (w_expire)
    );

    // Fill sequencing: latch the line base on a miss, then collect two beats.
    always_comb begin
        w_state_nxt      = r_state;
        w_base_nxt       = r_base;
        w_tag_nxt        = r_tag;
        w_line_valid_nxt = r_line_valid;
        w_line_nxt       = r_line;
        w_err_nxt        = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_miss) begin
                    w_state_nxt = S_BEAT0;
                    w_base_nxt  = io_bus.inst_sram_addr[31:3];
                end
`ifndef INST_SRAM_LINE_HIT_EN
                else if (io_bus.inst_sram_en) begin
                    // Served a hit this cycle; force the next request to refetch.
                    w_line_valid_nxt = 1'b0;
                end
`endif
            end
            S_BEAT0: begin
                if (w_advance) begin
                    w_line_nxt.lo = w_word;
                    w_state_nxt   = S_BEAT1;
                    if (!io_bus.mem_ack) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_BEAT1: begin
                if (w_advance) begin
                    w_line_nxt.hi    = w_word;
                    w_line_valid_nxt = 1'b1;
                    w_tag_nxt        = r_base;
                    w_state_nxt      = S_IDLE;
                    if (!io_bus.mem_ack) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and line registers; reset aborts any fill in progress.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_tag        <= '0;
            r_line_valid <= 1'b0;
            r_line       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_base       <= w_base_nxt;
            r_tag        <= w_tag_nxt;
            r_line_valid <= w_line_valid_nxt;
            r_line       <= w_line_nxt;
            r_err        <= w_err_nxt;
        end
    end

    // Outputs: line data only ever comes from the line register.
    always_comb begin
        io_bus.inst_sram_rdata = r_line;
        io_bus.stall_req       = io_bus.inst_sram_en && !w_hit;
        io_bus.mem_req         = w_in_beat;
        io_bus.err             = r_err;
        io_bus.mem_addr        = 32'h0;
        if (r_state == S_BEAT0) begin
            io_bus.mem_addr = beat_addr(r_base, 1'b0);
        end else if (r_state == S_BEAT1) begin
            io_bus.mem_addr = beat_addr(r_base, 1'b1);
        end
    end

endmodule

// File: tb/tb_inst_sram_resp.sv
// Self-checking bench for inst_sram_resp with MEM_TIMEOUT = 4.
module tb_inst_sram_resp;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        int          d0;
        int          d1;
        int          exp_stall;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_pass = 0;
    int   n_total = 0;

    // Memory responder controls.
    int   dly0 = 0;
    int   dly1 = 0;
    logic force_ack = 1'b0;
    int   rcnt = 0;
    logic prev_req = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    logic [31:0] q_addr[$];
    logic [63:0] q_rd[$];

    inst_sram_resp_if bus ();

    inst_sram_resp #(
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        if (a == 32'hbfbf_fff8) return 32'h1111_1111;
        if (a == 32'hbfbf_fffc) return 32'h2222_2222;
        return a ^ 32'ha5a5_0f0f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Backing memory: acks each beat after its configured delay, checks beat addresses.
    always @(negedge clk) begin
        if (!bus.mem_req) begin
            bus.mem_ack   = force_ack;
            bus.mem_rdata = 32'hbad0_bad0;
            rcnt = 0;
        end else begin
            if (!prev_req || (bus.mem_addr != prev_addr)) begin
                rcnt = 0;
                if (q_addr.size() == 0) begin
                    n_total++;
                    $display("FAIL beat_addr: unexpected beat at %h", bus.mem_addr);
                end else begin
                    chk("beat_addr", bus.mem_addr, q_addr.pop_front());
                end
            end
            if (rcnt == (bus.mem_addr[2] ? dly1 : dly0)) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mdata(bus.mem_addr);
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'hbad0_bad0;
            end
            rcnt++;
        end
        prev_req  = bus.mem_req;
        prev_addr = bus.mem_addr;
    end

    task automatic do_fetch(input vec_t v);
        int          stalls;
        logic [31:0] base;
        logic [31:0] lo;
        logic [31:0] hi;
        @(posedge clk);
        #1;
        dly0 = v.d0;
        dly1 = v.d1;
        bus.inst_sram_en    = 1'b1;
        bus.inst_sram_addr  = v.addr;
        bus.inst_sram_wen   = v.wen;
        bus.inst_sram_wdata = v.wdata;
        base = {v.addr[31:3], 3'b000};
        q_addr.push_back(base);
        q_addr.push_back(base + 32'd4);
        lo = (v.d0 >= TO) ? 32'h0 : mdata(base);
        hi = (v.d1 >= TO) ? 32'h0 : mdata(base + 32'd4);
        q_rd.push_back({hi, lo});
        stalls = 0;
        @(negedge clk);
        while (bus.stall_req && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        chk("stall_cycles", 64'(stalls), 64'(v.exp_stall));
        chk("rdata", bus.inst_sram_rdata, q_rd.pop_front());
        chk("err", {63'h0, bus.err}, {63'h0, v.exp_err});
        chk("beats_issued", 64'(q_addr.size()), 64'd0);
    endtask

    vec_t vecs[6];
    vec_t v;

    initial begin
        int   s_cnt;
        int   m_cnt;
        logic found;

        vecs[0] = '{32'hbfbf_fff8, 4'h0, 32'h0,         0,   0,   3, 1'b0};
        vecs[1] = '{32'h0000_1004, 4'h0, 32'h0,         0,   0,   3, 1'b0};
        vecs[2] = '{32'h0000_2000, 4'hf, 32'hdead_beef, 2,   1,   6, 1'b0};
        vecs[3] = '{32'h0000_3008, 4'h0, 32'h0,         0,   3,   6, 1'b0};
        vecs[4] = '{32'h0000_4010, 4'h0, 32'h0,         1,   255, 7, 1'b1};
        vecs[5] = '{32'h0000_5000, 4'h0, 32'h0,         255, 0,   6, 1'b1};

        // Reset state.
        resetn              = 1'b0;
        bus.inst_sram_en    = 1'b1;
        bus.inst_sram_addr  = 32'h0;
        bus.inst_sram_wen   = 4'h0;
        bus.inst_sram_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {63'h0, bus.mem_req}, 64'h0);
        chk("rst_mem_addr", {32'h0, bus.mem_addr}, 64'h0);
        chk("rst_rdata", bus.inst_sram_rdata, 64'h0);
        chk("rst_err", {63'h0, bus.err}, 64'h0);
        chk("rst_stall_en1", {63'h0, bus.stall_req}, 64'h1);
        bus.inst_sram_en = 1'b0;
        #1;
        chk("rst_stall_en0", {63'h0, bus.stall_req}, 64'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Table of fetches.
        for (int i = 0; i < 6; i++) do_fetch(vecs[i]);

        // Hold the same address after a fill.
        v = '{32'h0000_6000, 4'h0, 32'h0, 0, 0, 3, 1'b1};
        do_fetch(v);
`ifndef INST_SRAM_LINE_HIT_EN
        repeat (2) begin
            q_addr.push_back(32'h0000_6000);
            q_addr.push_back(32'h0000_6004);
        end
`endif
        s_cnt = 0;
        m_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.stall_req) s_cnt++;
            if (bus.mem_req) m_cnt++;
        end
`ifdef INST_SRAM_LINE_HIT_EN
        chk("hold_stalls", 64'(s_cnt), 64'd0);
        chk("hold_mem_req", 64'(m_cnt), 64'd0);
`else
        chk("hold_stalls", 64'(s_cnt), 64'd6);
        chk("hold_mem_req", 64'(m_cnt), 64'd4);
`endif
        chk("hold_beats", 64'(q_addr.size()), 64'd0);
        chk("hold_rdata", bus.inst_sram_rdata, {mdata(32'h6004), mdata(32'h6000)});
        @(posedge clk);
        #1;
        bus.inst_sram_en = 1'b0;

        // Reset in the middle of BEAT1, then a late ack.
        @(posedge clk);
        #1;
        dly0 = 0;
        dly1 = 255;
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = 32'h0000_7000;
        q_addr.push_back(32'h0000_7000);
        q_addr.push_back(32'h0000_7004);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_addr == 32'h0000_7004) found = 1'b1;
        end
        chk("reach_beat1", {63'h0, found}, 64'h1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        bus.inst_sram_en = 1'b0;
        force_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_mem_req", {63'h0, bus.mem_req}, 64'h0);
            chk("abort_mem_addr", {32'h0, bus.mem_addr}, 64'h0);
            chk("abort_rdata", bus.inst_sram_rdata, 64'h0);
            chk("abort_err", {63'h0, bus.err}, 64'h0);
        end
        force_ack = 1'b0;
        v = '{32'h0000_7000, 4'h0, 32'h0, 0, 0, 3, 1'b0};
        do_fetch(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
